fsm_parity_framer: RTL and testbench
====================================

# fsm_parity_framer

Parametrised serial parity generator FSM: accepts one data bit per qualified clock, groups bits into frames of FRAME_LEN, and emits one even- or odd-parity bit per completed frame with a one-cycle valid strobe. It is the general successor to the fixed 3-bit parity FSM. It supports arbitrary frame length, runtime parity mode, input qualification, synchronous frame abort and optional receive-side parity checking. It sits between a serial bit source and a framer/transmitter that appends the parity bit.

## Interface
- FRAME_LEN, 3, data bits per frame; legal range 1..255
- CNT_W, localparam = $clog2(FRAME_LEN+2), width of bit counter
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  qualifies in_bit this cycle
- in_bit  input  1  serial data bit
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled on first accepted bit of each frame
- clear  input  1  synchronous frame abort
- out_valid  output  1  one-cycle strobe: frame complete
- out_parity  output  1  parity bit of completed frame; held until next out_valid
- bit_count  output  CNT_W  bits accepted in current frame
- busy  output  1  high while a frame is partially received
- chk_err  output  1  parity mismatch strobe (only with PARITY_CHECK_EN; tied 0 otherwise)

## Operation
- States: IDLE (no bits), ACCUM (1..FRAME_LEN-1 data bits held), CHECK (macro only: all data bits held, awaiting received parity bit).
- Accept = in_valid & ~clear. Bits with in_valid=0 are ignored; state, counter and accumulator are held.
- IDLE + accept: acc <= in_bit, mode_q <= odd_mode, bit_count <= 1, go ACCUM (or complete immediately if FRAME_LEN=1).
- ACCUM + accept: acc <= acc ^ in_bit, bit_count++. When this is data bit FRAME_LEN, the frame completes: without the macro, go IDLE and emit; with the macro, go CHECK.
- Emitted parity = acc_final ^ mode_q. Even: total ones including the parity bit is even. Odd: the total is odd.
- odd_mode changes mid-frame have no effect on the current frame.
- clear: any state -> IDLE, bit_count <= 0, accumulator discarded, no out_valid and no chk_err. clear has priority over in_valid in the same cycle.
- busy = (state != IDLE).

## Timing
- Reset values: out_valid=0, out_parity=0, bit_count=0, busy=0, chk_err=0, state IDLE.
- Latency: out_valid and out_parity are registered. They are asserted the cycle after the clock edge that accepts the final bit of the frame (the last data bit, or the parity bit with the macro). out_valid is high for exactly 1 cycle.
- Back-to-back: the first bit of the next frame may be accepted in the same cycle out_valid is high. Maximum throughput is 1 bit/cycle with no bubble between frames.
- bit_count and busy update on the accepting edge, so they are visible the following cycle. bit_count returns to 0 on the edge that completes a frame.
- Asynchronous reset mid-frame: all outputs go to reset values immediately. The partial frame is lost and no strobe follows.
- clear in the cycle after completion does not suppress the already-registered out_valid.

## Configuration
- PARITY_CHECK_EN defined: each frame is FRAME_LEN data bits plus one received parity bit, accepted in CHECK. out_parity is the computed parity. chk_err pulses together with out_valid when the received bit != computed parity. bit_count reaches FRAME_LEN in CHECK.
- Not defined: there is no CHECK state, frames are FRAME_LEN bits, and chk_err is constant 0.

## Test plan
- FRAME_LEN=3, even mode, bits 0,0,1 on consecutive cycles -> out_valid 1 cycle after 3rd bit, out_parity=1. Repeat with 0,0,0 -> out_parity=0.
- Odd mode, bits 0,1,1 with in_valid gaps of 2 cycles between bits -> out_parity=1, single strobe. Toggling odd_mode after bit 1 leaves the result unchanged.
- Back-to-back frames 1,1,1 then 0,1,0 with no idle cycle, even mode -> strobes 3 cycles apart, parities 1 then 1. bit_count sequence is 1,2,0,1,2,0.
- clear after 2 bits, then 1,0,0 -> no strobe for the aborted frame, out_parity=1 for the new frame. clear+in_valid in the same cycle -> bit dropped.
- Reset asserted after 2 bits of a frame -> all outputs 0 immediately. A following full frame 0,1,1 (even) gives out_parity=0.
- PARITY_CHECK_EN, even mode, 0,0,1 then received 1 -> chk_err=0. Same data with received 0 -> chk_err=1, coincident with out_valid.

Source files
------------

// File: rtl/fsm_parity_framer.sv
// -----------------------------------------------------------------------------
// fsm_parity_framer
//
// Serial parity generator. Accepts one data bit per qualified clock, groups the
// bits into frames of FRAME_LEN and emits one even/odd parity bit per completed
// frame together with a one-cycle valid strobe. Frames can run back to back at
// one bit per cycle with no bubble.
//
// Optional feature (compile-time macro PARITY_CHECK_EN):
//   Each frame is followed by one received parity bit, taken in the CHECK
//   state. out_parity still carries the computed parity; chk_err pulses with
//   out_valid when the received bit disagrees. Without the macro there is no
//   CHECK state and chk_err is tied low.
//
// Parameters:
//   FRAME_LEN   data bits per frame (1..255)
//   CNT_W       width of bit_count, derived from FRAME_LEN
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   in_valid    qualifies in_bit this cycle
//   in_bit      serial data bit
//   odd_mode    0 = even, 1 = odd parity; latched on first bit of a frame
//   clear       synchronous frame abort, wins over in_valid
//   out_valid   one-cycle strobe, frame complete
//   out_parity  parity of last completed frame, held until next strobe
//   bit_count   bits accepted in the current frame
//   busy        high while a frame is partially received
//   chk_err     received parity mismatch strobe (macro build only)
// -----------------------------------------------------------------------------
module fsm_parity_framer #(
  parameter int unsigned FRAME_LEN = 3,
  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             odd_mode,
  input  logic             clear,
  output logic             out_valid,
  output logic             out_parity,
  output logic [CNT_W-1:0] bit_count,
  output logic             busy,
  output logic             chk_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
`ifdef PARITY_CHECK_EN
  localparam logic [1:0] ST_CHECK = 2'd2;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

  // State registers
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_acc;   // running XOR of accepted data bits
  logic             r_mode;  // parity mode latched at frame start
  logic             r_out_valid;
  logic             r_out_parity;

  // Next-state values
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_acc_nxt;
  logic             w_mode_nxt;
  logic             w_out_valid_nxt;
  logic             w_out_parity_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_frame_done;

`ifdef PARITY_CHECK_EN
  logic r_chk_err;
  logic w_chk_err_nxt;
`endif

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_acc_nxt        = r_acc;
    w_mode_nxt       = r_mode;
    w_out_valid_nxt  = 1'b0;
    w_out_parity_nxt = r_out_parity;
    w_frame_done     = 1'b0;
`ifdef PARITY_CHECK_EN
    w_chk_err_nxt    = 1'b0;
`endif

    if (clear) begin
      // Abort discards the partial frame silently.
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_acc_nxt   = 1'b0;
    end else if (in_valid) begin
      case (r_state)
        ST_IDLE: begin
          w_acc_nxt   = in_bit;
          w_mode_nxt  = odd_mode;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_ACCUM;
          if (FRAME_LEN == 1) w_frame_done = 1'b1;
        end
        ST_ACCUM: begin
          w_acc_nxt = r_acc ^ in_bit;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == LAST_CNT) w_frame_done = 1'b1;
        end
`ifdef PARITY_CHECK_EN
        ST_CHECK: begin
          // in_bit is the received parity bit for the frame just collected.
          w_out_valid_nxt  = 1'b1;
          w_out_parity_nxt = r_acc ^ r_mode;
          w_chk_err_nxt    = in_bit ^ r_acc ^ r_mode;
          w_state_nxt      = ST_IDLE;
          w_cnt_nxt        = '0;
          w_acc_nxt        = 1'b0;
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_acc_nxt   = 1'b0;
        end
      endcase

      if (w_frame_done) begin
`ifdef PARITY_CHECK_EN
        // Hold all data bits; bit_count stays at FRAME_LEN while waiting.
        w_state_nxt = ST_CHECK;
`else
        w_out_valid_nxt  = 1'b1;
        w_out_parity_nxt = w_acc_nxt ^ w_mode_nxt;
        w_state_nxt      = ST_IDLE;
        w_cnt_nxt        = '0;
        w_acc_nxt        = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_acc        <= 1'b0;
      r_mode       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_parity <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_acc        <= w_acc_nxt;
      r_mode       <= w_mode_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_parity <= w_out_parity_nxt;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chk_err <= 1'b0;
    end else begin
      r_chk_err <= w_chk_err_nxt;
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

  assign out_valid  = r_out_valid;
  assign out_parity = r_out_parity;
  assign bit_count  = r_cnt;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fsm_parity_framer.sv
module tb_fsm_parity_framer;

  localparam int unsigned FRAME_LEN = 3;
  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 2);

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_bit;
  logic             odd_mode;
  logic             clear;
  logic             out_valid;
  logic             out_parity;
  logic [CNT_W-1:0] bit_count;
  logic             busy;
  logic             chk_err;

  fsm_parity_framer #(
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .odd_mode  (odd_mode),
    .clear     (clear),
    .out_valid (out_valid),
    .out_parity(out_parity),
    .bit_count (bit_count),
    .busy      (busy),
    .chk_err   (chk_err)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus the state expected after the clock edge.
  typedef struct {
    logic v;
    logic b;
    logic m;
    logic c;
    int   cnt;
    logic bsy;
    logic done;
    logic par;
    logic err;
  } vec_t;

  typedef struct {
    logic par;
    logic err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic last_par = 1'b0;

  function automatic vec_t mk(logic v, logic b, logic m, logic c, int cnt, logic bsy,
                              logic done, logic par, logic err);
    vec_t x;
    x.v = v; x.b = b; x.m = m; x.c = c; x.cnt = cnt; x.bsy = bsy;
    x.done = done; x.par = par; x.err = err;
    return x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive, clock once, check at the next falling edge.
  task automatic step(vec_t x, string tag);
    exp_t e;
    in_valid = x.v;
    in_bit   = x.b;
    odd_mode = x.m;
    clear    = x.c;
    if (x.done) sb.push_back('{par: x.par, err: x.err});
    @(posedge clk);
    @(negedge clk);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(x.done));
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s.unexpected_strobe: got strobe expected none", tag);
      end else begin
        e = sb.pop_front();
        check({tag, ".out_parity"}, 32'(out_parity), 32'(e.par));
        check({tag, ".chk_err"}, 32'(chk_err), 32'(e.err));
        last_par = e.par;
      end
    end else begin
      check({tag, ".parity_hold"}, 32'(out_parity), 32'(last_par));
      check({tag, ".chk_err_idle"}, 32'(chk_err), 32'd0);
    end
    check({tag, ".bit_count"}, 32'(bit_count), 32'(x.cnt));
    check({tag, ".busy"}, 32'(busy), 32'(x.bsy));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_parity"}, 32'(out_parity), 32'd0);
    check({tag, ".bit_count"}, 32'(bit_count), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".chk_err"}, 32'(chk_err), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    odd_mode = 1'b0;
    clear    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

`ifndef PARITY_CHECK_EN
    //            v  b  m  c  cnt bsy done par err
    // even 0,0,1 -> 1
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 0));
    // even 0,0,0 -> 0
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
    // odd 0,1,1 with 2-cycle gaps, odd_mode toggled mid-frame -> 1
    tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // back-to-back even 1,1,1 -> 1 then 0,1,0 -> 1
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0));
    // clear after 2 bits, then 1,0,0 -> 1
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0));
    // clear with in_valid drops the bit; then 0,1,1 -> 0
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0));
    // even 0,1,1 -> 0 ... no: 1,1,0 -> 0, then clear while strobe is high
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    // odd 1,1,1 -> 0, then even 1,0,0 -> 1
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-frame after a frame that left out_parity = 1.
    step(mk(1, 0, 0, 0, 1, 1, 0, 0, 0), "pre_rst0");
    step(mk(1, 0, 0, 0, 2, 1, 0, 0, 0), "pre_rst1");
    step(mk(1, 1, 0, 0, 0, 0, 1, 1, 0), "pre_rst2");
    step(mk(1, 1, 0, 0, 1, 1, 0, 0, 0), "mid_rst0");
    step(mk(1, 0, 0, 0, 2, 1, 0, 0, 0), "mid_rst1");
    in_valid = 1'b1;
    in_bit   = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    last_par = 1'b0;
    @(negedge clk);
    check_reset_outputs("async_rst_held");
    reset    = 1'b0;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_idle");
    step(mk(1, 0, 0, 0, 1, 1, 0, 0, 0), "post_rst0");
    step(mk(1, 1, 0, 0, 2, 1, 0, 0, 0), "post_rst1");
    step(mk(1, 1, 0, 0, 0, 0, 1, 0, 0), "post_rst2");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_tail");
`else
    // Data bits then the received parity bit; bit_count parks at FRAME_LEN.
    // even 0,0,1 recv 1 -> parity 1, no error
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 0));
    // even 0,0,1 recv 0 -> parity 1, error with strobe
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 1));
    // clear in CHECK -> no strobe, no error
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    // odd 1,0,0 with gap in CHECK, recv 0 -> parity 0, no error
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
    // odd 1,1,1 recv 1 -> parity 0, error; back to back with next frame
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("chk%0d", i));
    end

    // Asynchronous reset while waiting for the received parity bit.
    step(mk(1, 0, 0, 0, 2, 1, 0, 0, 0), "chk_mid0");
    step(mk(1, 0, 0, 0, 3, 1, 0, 0, 0), "chk_mid1");
    in_valid = 1'b1;
    in_bit   = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    last_par = 1'b0;
    @(negedge clk);
    check_reset_outputs("async_rst_held");
    reset = 1'b0;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_idle");
`endif

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
